// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: stalls the pipeline while a MEM-stage load/store runs its memory handshake.
// Define DMEM_TIMEOUT_EN to abandon transactions stuck in REQ/WAIT for TIMEOUT_CYCLES cycles.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BubbleW,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_we;
    logic        w_access, w_busy, w_done_ok, w_capture, w_timeout, w_expire;
    assign w_access  = MemReadM | MemWriteM;
    assign w_busy    = (r_state == REQ) || (r_state == WAIT);
    // rvalid only counts in WAIT or in the REQ cycle that is accepted
    assign w_done_ok = (r_state == REQ && mem_ready && (r_we || mem_rvalid)) ||
                       (r_state == WAIT && mem_rvalid);
    assign w_capture = w_done_ok && !r_we;
    assign w_expire  = w_timeout && !w_done_ok;
`ifdef DMEM_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_err;
    assign w_timeout = w_busy && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign mem_err   = r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == IDLE && w_access) ? '0 : w_busy ? r_cnt + 16'd1 : r_cnt;
            r_err <= w_expire;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_access ? REQ : IDLE;
            REQ:     w_next = (w_done_ok || w_expire) ? DONE : mem_ready ? WAIT : REQ;
            WAIT:    w_next = (w_done_ok || w_expire) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_access) begin
                r_addr  <= ALUResultM;
                r_wdata <= WriteDataM;
                r_we    <= ~MemReadM;
            end
            if (w_capture) r_rdata <= mem_rdata;
            else if (w_expire) r_rdata <= '0;
        end
    end
    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ReadDataM = r_rdata;
    // reset drops the stall at once, even while the access is still presented
    assign StallM    = rst_n && ((r_state == IDLE && w_access) || w_busy);
    assign BubbleW   = StallM;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized load/store traffic against a sparse memory model and latency formula.
// Timeout checks run only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ReadDataM;
    logic        StallM, BubbleW, mem_err;
    int          errors = 0, checks = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] last_rd = '0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM), .BubbleW(BubbleW),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    // One MEM-stage instruction: the bench plays the memory with the given ready/rvalid delays
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rdy_dly, input int rv_dly);
        int nstall = 0, nreq = 0, since = 0;
        logic accepted = 1'b0, finished = 1'b0;
        int exp_stall = rd ? 2 + rdy_dly + rv_dly : 2 + rdy_dly;
        logic [31:0] exp_data = rd ? model_read(addr) : last_rd;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (cyc != 0) begin @(posedge clk); #1; end
            if (accepted) since++;
            mem_ready  = mem_req && (nreq == rdy_dly);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rd && mem_ready && rv_dly == 0) begin
                mem_rvalid = 1'b1; mem_rdata = exp_data;
            end else if (rd && accepted && since == rv_dly) begin
                mem_rvalid = 1'b1; mem_rdata = exp_data;
            end else if (!accepted && !mem_ready) begin
                mem_rvalid = 1'($urandom % 2);
            end
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                checks++;
                if (mem_we !== !rd || mem_addr !== addr || (!rd && mem_wdata !== wdata)) begin
                    errors++;
                    $display("FAIL req_fields: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, !rd, addr, wdata);
                end
                if (mem_ready) begin accepted = 1'b1; since = 0; end
            end
            checks++;
            if (BubbleW !== StallM || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL bubble_err: got BubbleW=%b StallM=%b mem_err=%b, required BubbleW=StallM mem_err=0",
                         BubbleW, StallM, mem_err);
            end
            if (StallM === 1'b1) nstall++;
            else finished = 1'b1;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL access_timeout: got no DONE in 200 cycles, required DONE");
        end
        checks++;
        if (nstall != exp_stall) begin
            errors++;
            $display("FAIL stall_count: got %0d, required %0d (rd=%b wr=%b rdy=%0d rv=%0d)",
                     nstall, exp_stall, rd, wr, rdy_dly, rv_dly);
        end
        checks++;
        if (nreq != rdy_dly + 1) begin
            errors++;
            $display("FAIL req_count: got %0d, required %0d", nreq, rdy_dly + 1);
        end
        checks++;
        if (ReadDataM !== exp_data) begin
            errors++;
            $display("FAIL read_data: got %h, required %h", ReadDataM, exp_data);
        end
        if (rd) last_rd = exp_data;
        else mem_model[addr] = wdata;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || mem_req !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL idle: got StallM=%b mem_req=%b mem_err=%b, required 0 0 0", StallM, mem_req, mem_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            ReadDataM !== '0 || StallM !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req=%b we=%b addr=%h wdata=%h rdata=%h stall=%b err=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, StallM, mem_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_directed();
        do_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        mem_model[32'h200] = 32'h1234_5678;
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 3);
        do_access(1'b1, 1'b1, 32'h100, 32'hFFFF_0000, 1, 0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 0);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 1);
        do_access(1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 0, 0);
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 0);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(1, 3);
            do_access(op[0], op[1], 32'h1000 + 32'(4 * $urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom % 4 == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        MemReadM = 1'b1; ALUResultM = 32'h400;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || BubbleW !== 1'b0 || mem_err !== 1'b0 ||
            mem_addr !== '0 || ReadDataM !== '0) begin
            errors++;
            $display("FAIL reset_wait: got req=%b stall=%b bubble=%b err=%b addr=%h rdata=%h, required all 0",
                     mem_req, StallM, BubbleW, mem_err, mem_addr, ReadDataM);
        end
        MemReadM = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 0);
        idle_cycle();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int nstall = 0;
        logic finished = 1'b0;
        @(posedge clk); #1;
        MemReadM = 1'b1; ALUResultM = 32'h500;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            @(negedge clk);
            if (StallM === 1'b1) nstall++;
            else finished = 1'b1;
            if (!finished) begin @(posedge clk); #1; end
        end
        checks++;
        if (!finished || nstall != TO + 1 || mem_err !== 1'b1 || ReadDataM !== '0) begin
            errors++;
            $display("FAIL timeout: got done=%b stalls=%0d err=%b rdata=%h, required 1 %0d 1 0",
                     finished, nstall, mem_err, ReadDataM, TO + 1);
        end
        last_rd = '0;
        idle_cycle();
    endtask
`else
    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h500, 32'h0, 3 * TO, 2 * TO);
        idle_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles a transaction may remain in REQ+WAIT (range 1..65535, 16-bit counter).
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- ALUResultM  in  32  effective address
- WriteDataM  in  32  store data
- mem_req  out  1  request to data memory
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  32  request address
- mem_wdata  out  32  request write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- ReadDataM  out  32  load result toward MEM/WB register
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- BubbleW  out  1  force RegWrite=0 into MEM/WB this cycle
- mem_err  out  1  one-cycle timeout pulse

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE; state, capture registers and counter registered on clk.
REQ-004 IDLE: if MemReadM|MemWriteM, SHALL capture address, wdata, mem_we (=~MemReadM) and go REQ; else stay IDLE.
REQ-005 MemReadM and MemWriteM both high SHALL be performed as a read only.
REQ-006 REQ: mem_req=1 with captured addr/wdata/we held stable; on mem_ready: write -> DONE; read with mem_rvalid same cycle -> capture mem_rdata, DONE; read without -> WAIT.
REQ-007 WAIT: mem_req=0; on mem_rvalid SHALL capture mem_rdata and go DONE.
REQ-008 DONE: SHALL go IDLE unconditionally; the instruction leaves MEM this cycle, and IDLE does not re-trigger on it.
REQ-009 StallM SHALL be 1 combinationally in IDLE-with-access, REQ and WAIT; 0 in DONE and idle-without-access.
REQ-010 BubbleW SHALL equal StallM.
REQ-011 ReadDataM SHALL present the captured read data register, updated only on capture.
REQ-012 mem_req SHALL be 0 in IDLE, WAIT and DONE.
REQ-013 Minimum latency: write with mem_ready in first REQ cycle = 2 stall cycles; read with mem_ready and mem_rvalid in first REQ cycle = 2 stall cycles.
REQ-014 mem_rvalid outside WAIT or REQ-with-ready SHALL be ignored.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, counter=0, mem_err=0, regardless of clk.
REQ-016 Reset mid-transaction SHALL abandon it; no DONE, no mem_err.

Configuration
REQ-017 With DMEM_TIMEOUT_EN defined, counter SHALL clear on IDLE->REQ, increment each REQ/WAIT cycle, and at TIMEOUT_CYCLES force DONE, load ReadDataM=0, and pulse mem_err for the DONE cycle.
REQ-018 Without DMEM_TIMEOUT_EN, no counter SHALL exist, REQ/WAIT wait indefinitely, and mem_err SHALL be tied 0.

Verification
REQ-019 Store addr 0x100, data 0xDEADBEEF, mem_ready=1 first REQ cycle -> mem_req 1 cycle with we=1, StallM=1 for 2 cycles, DONE next.
REQ-020 Load addr 0x200, mem_ready cycle 1, mem_rvalid 3 cycles later with 0x12345678 -> StallM 5 cycles, ReadDataM=0x12345678 in DONE.
REQ-021 MemReadM=MemWriteM=1 -> read request, mem_we=0.
REQ-022 rst_n low while in WAIT -> mem_req=0, state IDLE, StallM=0 same cycle, no mem_err.
REQ-023 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never -> DONE after 4 REQ cycles, mem_err=1 one cycle, ReadDataM=0.
REQ-024 Back-to-back loads in consecutive instructions -> DONE then second IDLE->REQ, no missed or duplicated request.
